// File: rtl/anim_sequencer_if.sv
// Request handshake and display-side outputs of the pet-screen animation sequencer.
interface anim_sequencer_if;
  logic       req_valid;
  logic [1:0] req_act;
  logic       req_ready;
  logic [1:0] anim_sel;
  logic [3:0] step;
  logic       frame_start;
  logic       busy;

  modport master (
    output req_valid,
    output req_act,
    input  req_ready,
    input  anim_sel,
    input  step,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_act,
    output req_ready,
    output anim_sel,
    output step,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/anim_sequencer.sv
// Animation sequencer: picks idle/eat/play/sleep and the frame index, switching
// animations only on loop boundaries. One-entry request buffer; idle timeout to sleep.
module anim_sequencer #(
  parameter int IDLE_FRAMES   = 16,
  parameter int ACT_FRAMES    = 8,
  parameter int ACT_LOOPS     = 3,
  parameter int SLEEP_TIMEOUT = 64
) (
  input  logic            clk_24,
  input  logic            rst,
  anim_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACT   = 2'd1,
    ST_SLEEP = 2'd2
  } state_t;

  localparam logic [1:0] ACT_WAKE  = 2'd0;
  localparam logic [1:0] ACT_EAT   = 2'd1;
  localparam logic [1:0] ACT_PLAY  = 2'd2;
  localparam logic [1:0] ACT_SLEEP = 2'd3;

  localparam logic [3:0] IDLE_LAST = 4'(IDLE_FRAMES - 1);
  localparam logic [3:0] ACT_LAST  = 4'(ACT_FRAMES - 1);
  localparam logic [3:0] LOOP_LAST = 4'(ACT_LOOPS - 1);
  localparam logic [7:0] TIMEOUT   = 8'(SLEEP_TIMEOUT);

  state_t     state_r, state_s;
  logic [3:0] step_r, step_s;
  logic [1:0] act_r, act_s;
  logic [3:0] loop_r, loop_s;
  logic [7:0] idle_cnt_r, idle_cnt_s;
  logic       pend_valid_r, pend_valid_s;
  logic [1:0] pend_act_r, pend_act_s;
  logic [1:0] anim_sel_r, anim_sel_s;
  logic [3:0] last_s;
  logic       le_s;
  logic       accept_s;
  logic       consume_s;

  // Loop-end detect and request handshake decode from current registers.
  always_comb begin
    last_s   = (state_r == ST_ACT) ? ACT_LAST : IDLE_LAST;
    le_s     = (step_r == last_s);
    accept_s = bus.req_valid && !pend_valid_r;
  end

  // Next state, frame step and loop counter; transitions happen only at loop end.
  always_comb begin
    state_s   = state_r;
    act_s     = act_r;
    loop_s    = loop_r;
    consume_s = 1'b0;
    step_s    = step_r + 4'd1;
    if (le_s) begin
      step_s = 4'd0;
      case (state_r)
        ST_IDLE: begin
          if (pend_valid_r) begin
            consume_s = 1'b1;
            case (pend_act_r)
              ACT_EAT, ACT_PLAY: begin
                state_s = ST_ACT;
                act_s   = pend_act_r;
                loop_s  = 4'd0;
              end
              ACT_SLEEP: state_s = ST_SLEEP;
              default:   state_s = ST_IDLE;
            endcase
          end else if (idle_cnt_r == TIMEOUT) begin
            state_s = ST_SLEEP;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ACT: begin
          if (pend_valid_r && (pend_act_r == ACT_WAKE)) begin
            // Cancel cuts the action short at this loop end.
            consume_s = 1'b1;
            state_s   = ST_IDLE;
          end else if (loop_r == LOOP_LAST) begin
            // Any other buffered request waits for the next idle loop end.
            state_s = ST_IDLE;
          end else begin
            loop_s = loop_r + 4'd1;
          end
        end
        ST_SLEEP: begin
          if (pend_valid_r) begin
            consume_s = 1'b1;
            // Anything but another sleep request only wakes the pet.
            if (pend_act_r != ACT_SLEEP) begin
              state_s = ST_IDLE;
            end else begin
              state_s = ST_SLEEP;
            end
          end else begin
            state_s = ST_SLEEP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          loop_s  = 4'd0;
        end
      endcase
    end else begin
      step_s = step_r + 4'd1;
    end
  end

  // Pending buffer, idle timer and the animation select that follows the next state.
  always_comb begin
    pend_valid_s = pend_valid_r;
    pend_act_s   = pend_act_r;
    if (accept_s) begin
      pend_valid_s = 1'b1;
      pend_act_s   = bus.req_act;
    end else if (consume_s) begin
      pend_valid_s = 1'b0;
    end else begin
      pend_valid_s = pend_valid_r;
    end

    idle_cnt_s = idle_cnt_r;
    if (accept_s) begin
      idle_cnt_s = 8'd0;
    end else if ((state_s == ST_IDLE) && (state_r != ST_IDLE)) begin
      idle_cnt_s = 8'd0;
    end else if ((state_r == ST_IDLE) && !pend_valid_r && (idle_cnt_r != TIMEOUT)) begin
      idle_cnt_s = idle_cnt_r + 8'd1;
    end else begin
      idle_cnt_s = idle_cnt_r;
    end

    case (state_s)
      ST_IDLE:  anim_sel_s = 2'd0;
      ST_ACT:   anim_sel_s = act_s;
      ST_SLEEP: anim_sel_s = 2'd3;
      default:  anim_sel_s = 2'd0;
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk_24 or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      step_r       <= 4'd0;
      act_r        <= 2'd0;
      loop_r       <= 4'd0;
      idle_cnt_r   <= 8'd0;
      pend_valid_r <= 1'b0;
      pend_act_r   <= 2'd0;
      anim_sel_r   <= 2'd0;
    end else begin
      state_r      <= state_s;
      step_r       <= step_s;
      act_r        <= act_s;
      loop_r       <= loop_s;
      idle_cnt_r   <= idle_cnt_s;
      pend_valid_r <= pend_valid_s;
      pend_act_r   <= pend_act_s;
      anim_sel_r   <= anim_sel_s;
    end
  end

  assign bus.anim_sel    = anim_sel_r;
  assign bus.step        = step_r;
  assign bus.frame_start = (step_r == 4'd0);
  assign bus.req_ready   = !pend_valid_r;
  assign bus.busy        = (state_r != ST_IDLE) || pend_valid_r;

endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: table of hand-derived vectors, hand-written corner
// sequences, then random requests compared against a behavioural model.
module tb_anim_sequencer;

  localparam int IDLE_F  = 16;
  localparam int ACT_F   = 8;
  localparam int LOOPS   = 3;
  localparam int TIMEOUT = 20;

  logic clk_24 = 1'b0;
  logic rst    = 1'b1;

  anim_sequencer_if bus();

  anim_sequencer #(
    .IDLE_FRAMES(IDLE_F),
    .ACT_FRAMES(ACT_F),
    .ACT_LOOPS(LOOPS),
    .SLEEP_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_24(clk_24),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_24 = ~clk_24;

  int n_vec  = 0;
  int n_fail = 0;

  // Behavioural model: mode 0 idle, 1 action, 2 sleep; pending buffer is a queue.
  int m_mode, m_act, m_step, m_loops, m_idle;
  int m_pend[$];

  task automatic model_reset();
    m_mode = 0; m_act = 0; m_step = 0; m_loops = 0; m_idle = 0;
    m_pend.delete();
  endtask

  task automatic model_edge(input bit v, input int a);
    int  last, old_mode, p;
    bit  had, accept;
    last     = (m_mode == 1) ? ACT_F - 1 : IDLE_F - 1;
    old_mode = m_mode;
    had      = (m_pend.size() != 0);
    p        = had ? m_pend[0] : -1;
    accept   = v && !had;
    if (m_step == last) begin
      m_step = 0;
      if (old_mode == 0) begin
        if (had) begin
          void'(m_pend.pop_front());
          if (p == 1 || p == 2) begin m_mode = 1; m_act = p; m_loops = 0; end
          else if (p == 3) m_mode = 2;
        end else if (m_idle >= TIMEOUT) m_mode = 2;
      end else if (old_mode == 1) begin
        if (had && p == 0) begin void'(m_pend.pop_front()); m_mode = 0; end
        else if (m_loops == LOOPS - 1) m_mode = 0;
        else m_loops++;
      end else begin
        if (had) begin
          void'(m_pend.pop_front());
          if (p != 3) m_mode = 0;
        end
      end
    end else begin
      m_step++;
    end
    if (accept || (m_mode == 0 && old_mode != 0)) m_idle = 0;
    else if (old_mode == 0 && !had && m_idle < TIMEOUT) m_idle++;
    if (accept) m_pend.push_back(a);
  endtask

  task automatic check(input string name, input int ea, input int es, input bit er, input bit eb);
    n_vec++;
    if (bus.anim_sel !== 2'(ea) || bus.step !== 4'(es) || bus.req_ready !== er ||
        bus.busy !== eb || bus.frame_start !== (es == 0)) begin
      n_fail++;
      $display("FAIL %s: got anim_sel=%0d step=%0d req_ready=%0d busy=%0d frame_start=%0d, want anim_sel=%0d step=%0d req_ready=%0d busy=%0d frame_start=%0d",
               name, bus.anim_sel, bus.step, bus.req_ready, bus.busy, bus.frame_start,
               ea, es, er, eb, (es == 0));
    end
  endtask

  task automatic check_model(input string name);
    int ea;
    ea = (m_mode == 0) ? 0 : (m_mode == 1) ? m_act : 3;
    check(name, ea, m_step, (m_pend.size() == 0), (m_mode != 0) || (m_pend.size() != 0));
  endtask

  task automatic tick(input bit v, input int a);
    bus.req_valid = v;
    bus.req_act   = 2'(a);
    @(posedge clk_24);
    model_edge(v, a);
    @(negedge clk_24);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk_24);
    @(negedge clk_24);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int ncyc;
    bit v;
    int act;
    int ea;
    int es;
    bit er;
    bit eb;
  } vec_t;

  vec_t tbl[20];

  initial begin
    bus.req_valid = 1'b0;
    bus.req_act   = 2'd0;

    // ncyc, valid, act -> anim_sel, step, req_ready, busy
    tbl[0]  = '{0,  1'b0, 0, 0, 0,  1'b1, 1'b0};  // reset state
    tbl[1]  = '{5,  1'b0, 0, 0, 5,  1'b1, 1'b0};
    tbl[2]  = '{10, 1'b0, 0, 0, 15, 1'b1, 1'b0};
    tbl[3]  = '{1,  1'b0, 0, 0, 0,  1'b1, 1'b0};  // first LE, timer at 16 < 20
    tbl[4]  = '{15, 1'b0, 0, 0, 15, 1'b1, 1'b0};
    tbl[5]  = '{1,  1'b0, 0, 3, 0,  1'b1, 1'b1};  // timeout -> sleep at cycle 32
    tbl[6]  = '{15, 1'b0, 0, 3, 15, 1'b1, 1'b1};
    tbl[7]  = '{1,  1'b0, 0, 3, 0,  1'b1, 1'b1};
    tbl[8]  = '{1,  1'b1, 1, 3, 1,  1'b0, 1'b1};  // eat while asleep
    tbl[9]  = '{14, 1'b0, 0, 3, 15, 1'b0, 1'b1};
    tbl[10] = '{1,  1'b0, 0, 0, 0,  1'b1, 1'b0};  // wake only, eat not started
    tbl[11] = '{5,  1'b0, 0, 0, 5,  1'b1, 1'b0};
    tbl[12] = '{1,  1'b1, 1, 0, 6,  1'b0, 1'b1};  // eat accepted at step 5
    tbl[13] = '{9,  1'b0, 0, 0, 15, 1'b0, 1'b1};
    tbl[14] = '{1,  1'b0, 0, 1, 0,  1'b1, 1'b1};  // eat starts at idle LE
    tbl[15] = '{7,  1'b0, 0, 1, 7,  1'b1, 1'b1};
    tbl[16] = '{1,  1'b0, 0, 1, 0,  1'b1, 1'b1};
    tbl[17] = '{8,  1'b0, 0, 1, 0,  1'b1, 1'b1};
    tbl[18] = '{7,  1'b0, 0, 1, 7,  1'b1, 1'b1};
    tbl[19] = '{1,  1'b0, 0, 0, 0,  1'b1, 1'b0};  // back to idle after 24 cycles

    @(negedge clk_24);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        tick((c == 0) ? tbl[i].v : 1'b0, tbl[i].act);
      end
      check($sformatf("table[%0d]", i), tbl[i].ea, tbl[i].es, tbl[i].er, tbl[i].eb);
    end

    // Play, then cancel queued mid-loop: idle at the end of the current loop.
    tick(1'b1, 2);
    check("cancel_accept", 0, 1, 1'b0, 1'b1);
    for (int c = 0; c < 15; c++) tick(1'b0, 0);
    check("cancel_play_start", 2, 0, 1'b1, 1'b1);
    tick(1'b0, 0);
    tick(1'b0, 0);
    tick(1'b1, 0);
    check("cancel_queued", 2, 3, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) tick(1'b0, 0);
    check("cancel_loop_end", 2, 7, 1'b0, 1'b1);
    tick(1'b0, 0);
    check("cancel_to_idle", 0, 0, 1'b1, 1'b0);

    // req_valid held high with play from reset.
    do_reset();
    check("held_reset", 0, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 57; i++) begin
      tick(1'b1, 2);
      if (i == 1)  check("held_e1",  0, 1,  1'b0, 1'b1);
      if (i == 15) check("held_e15", 0, 15, 1'b0, 1'b1);
      if (i == 16) check("held_e16", 2, 0,  1'b1, 1'b1);
      if (i == 17) check("held_e17", 2, 1,  1'b0, 1'b1);
      if (i == 39) check("held_e39", 2, 7,  1'b0, 1'b1);
      if (i == 40) check("held_e40", 0, 0,  1'b0, 1'b1);
      if (i == 56) check("held_e56", 2, 0,  1'b1, 1'b1);
      if (i == 57) check("held_e57", 2, 1,  1'b0, 1'b1);
      check_model("held_model");
    end

    // Asynchronous reset during action at step 4, with a request buffered.
    for (int c = 0; c < 3; c++) tick(1'b0, 0);
    check("pre_reset_act", 2, 4, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset", 0, 0, 1'b1, 1'b0);
    @(posedge clk_24);
    @(negedge clk_24);
    rst = 1'b0;
    model_reset();
    check("reset_release", 0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) tick(1'b0, 0);
    check("post_reset_count", 0, 5, 1'b1, 1'b0);

    // Random requests at several densities against the model.
    for (int blk = 0; blk < 6; blk++) begin
      int div;
      div = (blk % 3 == 0) ? 2 : (blk % 3 == 1) ? 8 : 64;
      for (int c = 0; c < 500; c++) begin
        tick(($urandom_range(0, div - 1) == 0), int'($urandom_range(0, 3)));
        check_model("random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
